// File: rtl/paralelo_serial_param.sv
// Parallel-to-serial converter on the bit clock: one-word hold buffer, idle/COM
// fill for empty slots and an idle preamble after every reset.
module paralelo_serial_param #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] IDLE_SYM   = 8'hBC,
  parameter int               MSB_FIRST  = 1,
  parameter int               INIT_IDLES = 4
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             data_out,
  output logic             word_start,
  output logic             idle_out
);

  localparam int CNT_W  = $clog2(WIDTH);
  localparam int INIT_W = $clog2(INIT_IDLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [INIT_W-1:0] INIT_MAX = INIT_W'(INIT_IDLES);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [INIT_W-1:0]  r_init_cnt;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   r_hold_data;
  logic               r_hold_valid;

  logic               w_load, w_accept, w_init_inc, w_take_hold, w_bypass;
  logic               w_hold_wr, w_hold_valid_nxt, w_sym_idle;
  logic [WIDTH-1:0]   w_sym;

  function automatic logic first_bit(input logic [WIDTH-1:0] s);
    return (MSB_FIRST != 0) ? s[WIDTH-1] : s[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_rest(input logic [WIDTH-1:0] s);
    return (MSB_FIRST != 0) ? (s << 1) : (s >> 1);
  endfunction

  always_ff @(posedge clk_32f) begin
    if (reset) r_state <= ST_INIT;
    else       r_state <= w_state_nxt;
  end

  // Symbol selection at load edges; the INIT->RUN edge already uses RUN rules.
  always_comb begin
    w_load      = (r_cnt == CNT_LAST);
    w_accept    = valid_in & ready_out;
    w_state_nxt = r_state;
    w_sym       = IDLE_SYM;
    w_sym_idle  = 1'b1;
    w_init_inc  = 1'b0;
    w_take_hold = 1'b0;
    w_bypass    = 1'b0;
    if (w_load) begin
      if (r_state == ST_INIT && r_init_cnt < INIT_MAX) begin
        w_init_inc = 1'b1;
      end else begin
        w_state_nxt = ST_RUN;
        if (r_hold_valid) begin
          w_sym       = r_hold_data;
          w_sym_idle  = 1'b0;
          w_take_hold = 1'b1;
        end else if (w_accept) begin
          w_sym      = data_in;
          w_sym_idle = 1'b0;
          w_bypass   = 1'b1;
        end
      end
    end
    w_hold_wr        = w_accept & ~w_bypass;
    w_hold_valid_nxt = r_hold_valid;
    if (w_take_hold)    w_hold_valid_nxt = 1'b0;
    else if (w_hold_wr) w_hold_valid_nxt = 1'b1;
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_cnt        <= CNT_LAST;
      r_init_cnt   <= '0;
      r_hold_valid <= 1'b0;
      ready_out    <= 1'b0;
      data_out     <= 1'b0;
      word_start   <= 1'b0;
      idle_out     <= 1'b0;
    end else begin
      r_cnt        <= w_load ? '0 : r_cnt + 1'b1;
      if (w_init_inc) r_init_cnt <= r_init_cnt + 1'b1;
      r_hold_valid <= w_hold_valid_nxt;
      ready_out    <= ~w_hold_valid_nxt;
      word_start   <= w_load;
      if (w_load) begin
        data_out <= first_bit(w_sym);
        idle_out <= w_sym_idle;
      end else begin
        data_out <= first_bit(r_shift);
      end
    end
  end

  // Datapath: shift register keeps the not-yet-sent bits of the current symbol.
  always_ff @(posedge clk_32f) begin
    r_shift <= w_load ? shift_rest(w_sym) : shift_rest(r_shift);
    if (w_hold_wr) r_hold_data <= data_in;
  end

endmodule

// File: tb/tb_paralelo_serial_param.sv
// Bench for paralelo_serial_param: an 8-bit MSB-first instance checked every cycle
// against a symbol-slot model, plus a 10-bit LSB-first instance with fixed streams.
module tb_paralelo_serial_param;

  localparam int         W8    = 8;
  localparam int         INIT8 = 4;
  localparam logic [7:0] IDLE8 = 8'hBC;

  logic       clk = 1'b0;
  logic       rst8, valid8, rdy8, do8, ws8, id8;
  logic [7:0] data8;
  logic       rst10, valid10, rdy10, do10, ws10, id10;
  logic [9:0] data10;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  paralelo_serial_param dut8 (
    .clk_32f(clk), .reset(rst8), .data_in(data8), .valid_in(valid8),
    .ready_out(rdy8), .data_out(do8), .word_start(ws8), .idle_out(id8)
  );

  paralelo_serial_param #(
    .WIDTH(10), .IDLE_SYM(10'h17C), .MSB_FIRST(0), .INIT_IDLES(2)
  ) dut10 (
    .clk_32f(clk), .reset(rst10), .data_in(data10), .valid_in(valid10),
    .ready_out(rdy10), .data_out(do10), .word_start(ws10), .idle_out(id10)
  );

  // Reference: symbols occupy back-to-back WIDTH-cycle slots starting at the first
  // edge after reset; the first INIT8 slots are idle, later slots carry the oldest
  // accepted word (accepted on or before the slot's first edge) or idle.
  logic [7:0] q[$];
  int         m_pos   = 0;
  bit         m_fresh = 1'b1;
  int         m_nsym  = 0;
  logic [7:0] m_sym   = 8'h00;
  bit         m_idle  = 1'b0;
  bit         m_ready = 1'b0;
  logic [3:0] exp8    = 4'b0000;

  always @(posedge clk) begin
    if (rst8) begin
      q.delete();
      m_fresh = 1'b1;
      m_nsym  = 0;
      m_ready = 1'b0;
      exp8    = 4'b0000;
    end else begin
      if (valid8 && m_ready) q.push_back(data8);
      if (m_fresh || m_pos == W8 - 1) begin
        m_fresh = 1'b0;
        m_pos   = 0;
        if (m_nsym < INIT8) begin
          m_sym = IDLE8; m_idle = 1'b1; m_nsym++;
        end else if (q.size() > 0) begin
          m_sym = q.pop_front(); m_idle = 1'b0;
        end else begin
          m_sym = IDLE8; m_idle = 1'b1;
        end
      end else begin
        m_pos++;
      end
      m_ready = (q.size() == 0);
      exp8    = {m_sym[W8-1-m_pos], (m_pos == 0), m_idle, m_ready};
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst8 = 1'b1; valid8 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if ({do8, ws8, id8, rdy8} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset cyc %0d: got %b want 0000", k, {do8, ws8, id8, rdy8});
      end
    end
    rst8 = 1'b0;
  endtask

  task automatic test_idle_preamble();
    logic [7:0] s;
    logic [3:0] want;
    s = IDLE8;
    valid8 = 1'b0;
    for (int k = 0; k < 48; k++) begin
      tick();
      want = {s[7-(k%8)], (k % 8) == 0, 1'b1, 1'b1};
      n_tests++;
      if ({do8, ws8, id8, rdy8} !== want) begin
        n_fail++;
        $display("FAIL idle_preamble cyc %0d: got %b want %b", k, {do8, ws8, id8, rdy8}, want);
      end
      n_tests++;
      if ({do8, ws8, id8, rdy8} !== exp8) begin
        n_fail++;
        $display("FAIL idle_model cyc %0d: got %b want %b", k, {do8, ws8, id8, rdy8}, exp8);
      end
    end
  endtask

  task automatic test_hold_during_init();
    logic [7:0] got;
    bit         acc;
    bit         idle_seen;
    got = 8'h00; idle_seen = 1'b0;
    rst8 = 1'b1;
    tick(); tick();
    rst8 = 1'b0; valid8 = 1'b1; data8 = 8'h9D;
    for (int k = 0; k < 48; k++) begin
      acc = valid8 && m_ready;
      tick();
      if (acc) valid8 = 1'b0;
      n_tests++;
      if ({do8, ws8, id8, rdy8} !== exp8) begin
        n_fail++;
        $display("FAIL hold_init cyc %0d: got %b want %b", k, {do8, ws8, id8, rdy8}, exp8);
      end
      if (k >= 32 && k < 40) begin
        got = {got[6:0], do8};
        if (id8) idle_seen = 1'b1;
      end
    end
    n_tests++;
    if (got !== 8'h9D || idle_seen) begin
      n_fail++;
      $display("FAIL hold_init_word: got %h idle=%0d want 9d idle=0", got, idle_seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  words[3];
    logic [23:0] got;
    int idx, nbits, first, last;
    bit acc;
    words[0] = 8'hFF; words[1] = 8'hEE; words[2] = 8'hAF;
    got = '0; idx = 0; nbits = 0; first = -1; last = -1;
    valid8 = 1'b1; data8 = words[0];
    for (int k = 0; k < 60; k++) begin
      acc = valid8 && m_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx < 3) data8 = words[idx];
        else         valid8 = 1'b0;
      end
      n_tests++;
      if ({do8, ws8, id8, rdy8} !== exp8) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d: got %b want %b", k, {do8, ws8, id8, rdy8}, exp8);
      end
      if (!id8) begin
        got = {got[22:0], do8};
        nbits++;
        if (first < 0) first = k;
        last = k;
      end
    end
    n_tests++;
    if (got !== 24'hFFEEAF || nbits != 24 || last - first != 23) begin
      n_fail++;
      $display("FAIL back_to_back_stream: got %h bits=%0d span=%0d want ffeeaf bits=24 span=23",
               got, nbits, last - first);
    end
  endtask

  task automatic test_bypass();
    logic [7:0] got;
    bit found, ready_drop;
    found = 1'b0; ready_drop = 1'b0;
    valid8 = 1'b0;
    for (int k = 0; k < 24 && !found; k++) begin
      if (m_pos == W8 - 1 && q.size() == 0 && m_nsym >= INIT8) found = 1'b1;
      else tick();
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL bypass_wait: got no idle RUN load edge want one within 24 cycles");
    end
    valid8 = 1'b1; data8 = 8'h3C;
    tick();
    valid8 = 1'b0;
    n_tests++;
    if ({do8, ws8, id8, rdy8} !== 4'b0101) begin
      n_fail++;
      $display("FAIL bypass_first_bit: got %b want 0101", {do8, ws8, id8, rdy8});
    end
    got = {7'b0, do8};
    for (int k = 1; k < 8; k++) begin
      tick();
      got = {got[6:0], do8};
      if (!rdy8) ready_drop = 1'b1;
      n_tests++;
      if ({do8, ws8, id8, rdy8} !== exp8) begin
        n_fail++;
        $display("FAIL bypass cyc %0d: got %b want %b", k, {do8, ws8, id8, rdy8}, exp8);
      end
    end
    n_tests++;
    if (got !== 8'h3C || ready_drop) begin
      n_fail++;
      $display("FAIL bypass_word: got %h ready_drop=%0d want 3c ready_drop=0", got, ready_drop);
    end
  endtask

  task automatic test_reset_mid();
    bit acc, done;
    logic [7:0] words[2];
    words[0] = 8'h5A; words[1] = 8'h66;
    for (int w = 0; w < 2; w++) begin
      valid8 = 1'b1; data8 = words[w]; done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
        acc = valid8 && m_ready;
        tick();
        if (acc) begin valid8 = 1'b0; done = 1'b1; end
        n_tests++;
        if ({do8, ws8, id8, rdy8} !== exp8) begin
          n_fail++;
          $display("FAIL reset_mid_fill cyc %0d: got %b want %b", k, {do8, ws8, id8, rdy8}, exp8);
        end
      end
      n_tests++;
      if (!done) begin
        n_fail++;
        $display("FAIL reset_mid_accept: got no accept of %h want accept within 40 cycles", words[w]);
      end
    end
    tick(); tick();
    n_tests++;
    if (id8 !== 1'b0 || rdy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_setup: got idle=%b ready=%b want idle=0 ready=0", id8, rdy8);
    end
    rst8 = 1'b1;
    tick();
    n_tests++;
    if ({do8, ws8, id8, rdy8} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got %b want 0000", {do8, ws8, id8, rdy8});
    end
    rst8 = 1'b0;
    for (int k = 0; k < 64; k++) begin
      tick();
      n_tests++;
      if ({do8, ws8, id8, rdy8} !== exp8 || id8 !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_mid_after cyc %0d: got %b want %b", k, {do8, ws8, id8, rdy8}, exp8);
      end
    end
  endtask

  task automatic test_random();
    bit acc;
    int rst_left;
    rst_left = 0;
    for (int k = 0; k < 600; k++) begin
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) rst8 = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        rst8 = 1'b1; valid8 = 1'b0; rst_left = 2;
      end
      if (!rst8 && !valid8 && ($urandom_range(0, 2) == 0)) begin
        valid8 = 1'b1;
        data8  = 8'($urandom);
      end
      acc = valid8 && m_ready && !rst8;
      tick();
      if (acc) valid8 = 1'b0;
      n_tests++;
      if ({do8, ws8, id8, rdy8} !== exp8) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %b want %b", k, {do8, ws8, id8, rdy8}, exp8);
      end
    end
    rst8 = 1'b0; valid8 = 1'b0;
  endtask

  task automatic test_lsb_first_w10();
    logic [9:0] s;
    logic [3:0] want;
    bit         rdy_exp;
    rst10 = 1'b1; valid10 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_tests++;
      if ({do10, ws10, id10, rdy10} !== 4'b0000) begin
        n_fail++;
        $display("FAIL w10_reset cyc %0d: got %b want 0000", k, {do10, ws10, id10, rdy10});
      end
    end
    rst10 = 1'b0; valid10 = 1'b1; data10 = 10'h2A5;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (k == 1) valid10 = 1'b0;
      s       = (k / 10 == 2) ? 10'h2A5 : 10'h17C;
      rdy_exp = (k == 0) || (k >= 20);
      want    = {s[k%10], (k % 10) == 0, (k / 10) != 2, rdy_exp};
      n_tests++;
      if ({do10, ws10, id10, rdy10} !== want) begin
        n_fail++;
        $display("FAIL w10_lsb cyc %0d: got %b want %b", k, {do10, ws10, id10, rdy10}, want);
      end
    end
  endtask

  initial begin
    rst8 = 1'b1; valid8 = 1'b0; data8 = 8'h00;
    rst10 = 1'b1; valid10 = 1'b0; data10 = 10'h000;
    @(negedge clk);
    test_reset();
    test_idle_preamble();
    test_hold_during_init();
    test_back_to_back();
    test_bypass();
    test_reset_mid();
    test_random();
    test_lsb_first_w10();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
